// File: rtl/block_field_if.sv
// block_field_if: row generator handshake between the field and its row source
interface block_field_if #(
  parameter int LAYER_WIDTH = 7,
  parameter int TYPE_W      = 2
);
  logic                          row_req;
  logic                          row_valid;
  logic [LAYER_WIDTH*TYPE_W-1:0] row_in;
  modport master (output row_req, input row_valid, input row_in);
  modport slave  (input row_req, output row_valid, output row_in);
endinterface

// File: rtl/block_field.sv
// block_field: SkyHop game field with jump validation, timed scroll and row refill
module block_field #(
  parameter int NUM_LAYERS  = 5,
  parameter int LAYER_WIDTH = 7,
  parameter int TYPE_W      = 2,
  parameter int CHAR_ROW    = 3,
  parameter int START_POS   = 3,
  parameter int SCROLL_MS   = 100,
  parameter int SCORE_W     = 10,
  localparam int RW    = $clog2(NUM_LAYERS),
  localparam int CW    = $clog2(LAYER_WIDTH),
  localparam int PW    = $clog2(SCROLL_MS + 1),
  localparam int ROW_W = LAYER_WIDTH * TYPE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                module_en,
  input  logic                one_ms_tick,
  input  logic                jump_left,
  input  logic                jump_right,
  block_field_if.master       row,
  input  logic [RW-1:0]       rd_row,
  input  logic [CW-1:0]       rd_col,
  output logic [TYPE_W-1:0]   rd_data,
  output logic [CW-1:0]       char_pos,
  output logic [PW-1:0]       scroll_phase,
  output logic                busy,
  output logic                jump_fail,
  output logic [SCORE_W-1:0]  score
);
  localparam int FW = $clog2(CHAR_ROW + 1);
  localparam logic [ROW_W-1:0] INIT_ROW = ROW_W'(1) << (START_POS * TYPE_W);
  typedef enum logic [2:0] {FILL, IDLE, SCROLL, FETCH, FAILED} state_t;
  state_t             state, next_state;
  logic [ROW_W-1:0]   rows [NUM_LAYERS];
  logic [FW-1:0]      fill_cnt;
  logic               go_left, go_right, jump, edge_hit, fail, scroll_done, shift;
  logic [CW-1:0]      target;
  logic [1:0]         land;
  logic [SCORE_W:0]   sum;
  assign busy = state != IDLE;
  // jump evaluation against the landing row, and next-state selection
  always_comb begin
    go_left     = jump_left & ~jump_right;
    go_right    = jump_right & ~jump_left;
    jump        = go_left | go_right;
    edge_hit    = go_left ? char_pos == '0 : 32'(char_pos) == LAYER_WIDTH - 1;
    target      = go_left ? char_pos - 1'b1 : char_pos + 1'b1;
    land        = edge_hit ? 2'd0 : rows[CHAR_ROW-1][target*TYPE_W +: 2];
    fail        = edge_hit || !(land == 2'd1 || land == 2'd2);
    sum         = {1'b0, score} + (SCORE_W+1)'(land == 2'd2 ? 2 : 1);
    scroll_done = one_ms_tick && 32'(scroll_phase) == SCROLL_MS - 1;
    shift       = row.row_valid && (state == FILL || state == FETCH);
    next_state  = state;
    case (state)
      FILL:    next_state = row.row_valid && 32'(fill_cnt) == CHAR_ROW - 1 ? IDLE : FILL;
      IDLE:    next_state = jump ? (fail ? FAILED : SCROLL) : IDLE;
      SCROLL:  next_state = scroll_done ? FETCH : SCROLL;
      FETCH:   next_state = row.row_valid ? IDLE : FETCH;
      default: next_state = FAILED;
    endcase
  end
  // state register; a disabled module sits in FILL
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= module_en ? next_state : FILL;
  // field contents, character, score, scroll timing and renderer readout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_LAYERS; r++) rows[r] <= r == CHAR_ROW ? INIT_ROW : '0;
      fill_cnt     <= '0;
      char_pos     <= CW'(START_POS);
      score        <= '0;
      jump_fail    <= 1'b0;
      scroll_phase <= '0;
      row.row_req  <= 1'b0;
      rd_data      <= '0;
    end else if (!module_en) begin
      for (int r = 0; r < NUM_LAYERS; r++) rows[r] <= r == CHAR_ROW ? INIT_ROW : '0;
      fill_cnt     <= '0;
      char_pos     <= CW'(START_POS);
      score        <= '0;
      jump_fail    <= 1'b0;
      scroll_phase <= '0;
      row.row_req  <= 1'b0;
      rd_data      <= '0;
    end else begin
      rd_data     <= 32'(rd_row) < NUM_LAYERS && 32'(rd_col) < LAYER_WIDTH ? rows[rd_row][rd_col*TYPE_W +: TYPE_W] : '0;
      row.row_req <= next_state == FILL || next_state == FETCH;
      if (shift) begin
        rows[0] <= row.row_in;
        for (int r = 1; r < NUM_LAYERS; r++)
          if (state == FETCH || r < CHAR_ROW) rows[r] <= rows[r-1];
      end
      if (state == FILL && row.row_valid) fill_cnt <= fill_cnt + 1'b1;
      if (state == IDLE && jump && fail) jump_fail <= 1'b1;
      if (state == IDLE && jump && !fail) begin
        char_pos <= target;
        score    <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      end
      if (state == SCROLL && one_ms_tick) scroll_phase <= scroll_done ? '0 : scroll_phase + 1'b1;
    end
  end
endmodule
